// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared defaults, slot event type and saturation width rule for the mole board
package mole_pkg;

  localparam int DEF_N_HOLES = 5;
  localparam int DEF_LIFE_W  = 8;
  localparam int DEF_SCORE_W = 8;

  // One guard bit above the wider operand lets a sum be compared against the ceiling before truncation.
  localparam int SAT_GUARD_BITS = 1;

  typedef struct packed {
    logic valid_hit;
    logic expire;
  } slot_evt_t;

  function automatic int sat_width(input int score_w, input int inc_w);
    return ((score_w > inc_w) ? score_w : inc_w) + SAT_GUARD_BITS;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// rtl/mole_slot.sv - one hole: active bit, lifetime down-counter, hit/expire events and load override
module mole_slot
  import mole_pkg::*;
#(
  parameter int LIFE_W = DEF_LIFE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              load,
  input  logic [LIFE_W-1:0] life,
  output logic              active,
  output slot_evt_t         evt
);

  logic [LIFE_W-1:0] cnt;

  // A hit on the final cycle wins over expiry.
  always_comb begin
    evt.valid_hit = hit & active;
    evt.expire    = active & ~hit & (cnt == LIFE_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= life;
    end else if (evt.valid_hit || evt.expire) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active && (cnt != '0)) begin
      cnt <= cnt - LIFE_W'(1);
    end
  end

endmodule

// File: rtl/mole_board.sv
// rtl/mole_board.sv - whack-a-mole board with saturating score; MOLE_MISS_PENALTY_EN enables miss penalty
module mole_board
  import mole_pkg::*;
#(
  parameter int N_HOLES = DEF_N_HOLES,
  parameter int LIFE_W  = DEF_LIFE_W,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [N_HOLES-1:0] loadval,
  input  logic [LIFE_W-1:0]  life,
  input  logic [N_HOLES-1:0] hit,
  input  logic               clear_score,
  output logic               score_trigger,
  output logic               miss_trigger,
  output logic               escape_trigger,
  output logic [N_HOLES-1:0] board_state,
  output logic [SCORE_W-1:0] score
);

  localparam int PC_W  = $clog2(N_HOLES + 1);
  localparam int EXT_W = sat_width(SCORE_W, PC_W);
  localparam logic [EXT_W-1:0] SCORE_MAX = {{(EXT_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic [N_HOLES-1:0] valid_hits;
  logic [N_HOLES-1:0] expires;
  logic [PC_W-1:0]    hit_cnt;
  logic [EXT_W-1:0]   sum;
  logic [SCORE_W-1:0] score_next;
  logic               sat_unused;

  function automatic logic [PC_W-1:0] popcount(input logic [N_HOLES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_HOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  for (genvar g = 0; g < N_HOLES; g++) begin : g_slot
    slot_evt_t evt;

    mole_slot #(.LIFE_W(LIFE_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .hit    (hit[g]),
      .load   (load & loadval[g]),
      .life   (life),
      .active (board_state[g]),
      .evt    (evt)
    );

    assign valid_hits[g] = evt.valid_hit;
    assign expires[g]    = evt.expire;
  end

  assign hit_cnt = popcount(valid_hits);

`ifdef MOLE_MISS_PENALTY_EN
  logic [N_HOLES-1:0] misses;
  logic [PC_W-1:0]    miss_cnt;

  assign misses   = hit & ~board_state;
  assign miss_cnt = popcount(misses);
`endif

  // Increments saturate first; the miss penalty then floors at zero.
  always_comb begin
    sum = EXT_W'(score) + EXT_W'(hit_cnt);
    if (sum > SCORE_MAX) sum = SCORE_MAX;
`ifdef MOLE_MISS_PENALTY_EN
    if (sum > EXT_W'(miss_cnt)) sum = sum - EXT_W'(miss_cnt);
    else sum = '0;
`endif
    score_next = sum[SCORE_W-1:0];
  end

  assign sat_unused = ^sum[EXT_W-1:SCORE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score          <= '0;
      score_trigger  <= 1'b0;
      escape_trigger <= 1'b0;
    end else begin
      score          <= clear_score ? '0 : score_next;
      score_trigger  <= |valid_hits;
      escape_trigger <= |expires;
    end
  end

`ifdef MOLE_MISS_PENALTY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) miss_trigger <= 1'b0;
    else miss_trigger <= |misses;
  end
`else
  assign miss_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_mole_board.sv
// tb/tb_mole_board.sv - directed and random checks of mole_board against a deadline-based reference model
module tb_mole_board;

  localparam int N   = 5;
  localparam int LW  = 8;
  localparam int SW  = 8;
  localparam int SWS = 4;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [N-1:0]  loadval;
  logic [LW-1:0] life;
  logic [N-1:0]  hit;
  logic          clear_score;

  logic          st_b, mt_b, et_b;
  logic [N-1:0]  board_b;
  logic [SW-1:0] score_b;
  logic          st_s, mt_s, et_s;
  logic [N-1:0]  board_s;
  logic [SWS-1:0] score_s;

  mole_board u_big (
    .clk(clk), .rst_n(rst_n), .load(load), .loadval(loadval), .life(life), .hit(hit),
    .clear_score(clear_score), .score_trigger(st_b), .miss_trigger(mt_b),
    .escape_trigger(et_b), .board_state(board_b), .score(score_b)
  );

  mole_board #(.SCORE_W(SWS)) u_small (
    .clk(clk), .rst_n(rst_n), .load(load), .loadval(loadval), .life(life), .hit(hit),
    .clear_score(clear_score), .score_trigger(st_s), .miss_trigger(mt_s),
    .escape_trigger(et_s), .board_state(board_s), .score(score_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: each mole carries the absolute edge number at which it escapes (0 = never).
  bit act[N];
  int deadline[N];
  int edge_no = 0;
  int m_score, m_score_s;
  bit m_st, m_mt, m_et;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_board();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = act[i];
    return b;
  endfunction

  task automatic model_step();
    int hits;
    int esc;
    int misses;
    edge_no++;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        act[i] = 0;
        deadline[i] = 0;
      end
      m_score = 0; m_score_s = 0;
      m_st = 0; m_mt = 0; m_et = 0;
      return;
    end
    hits = 0; esc = 0; misses = 0;
    for (int i = 0; i < N; i++) begin
      if (hit[i] && act[i]) begin
        hits++;
        act[i] = 0;
      end else if (hit[i]) begin
        misses++;
      end else if (act[i] && deadline[i] == edge_no) begin
        esc++;
        act[i] = 0;
      end
    end
    if (load) begin
      for (int i = 0; i < N; i++) begin
        if (loadval[i]) begin
          act[i] = 1;
          deadline[i] = (life == 0) ? 0 : edge_no + int'(life);
        end
      end
    end
    m_score   = (m_score + hits > 255) ? 255 : m_score + hits;
    m_score_s = (m_score_s + hits > 15) ? 15 : m_score_s + hits;
`ifdef MOLE_MISS_PENALTY_EN
    m_score   = (m_score > misses) ? m_score - misses : 0;
    m_score_s = (m_score_s > misses) ? m_score_s - misses : 0;
    m_mt = (misses > 0);
`else
    m_mt = 0;
`endif
    if (clear_score) begin
      m_score = 0;
      m_score_s = 0;
    end
    m_st = (hits > 0);
    m_et = (esc > 0);
  endtask

  task automatic compare_all();
    chk("board_big", board_b, m_board());
    chk("board_small", board_s, m_board());
    chk("score_big", score_b, m_score);
    chk("score_small", score_s, m_score_s);
    chk("score_trig_big", st_b, m_st);
    chk("score_trig_small", st_s, m_st);
    chk("miss_trig_big", mt_b, m_mt);
    chk("miss_trig_small", mt_s, m_mt);
    chk("escape_trig_big", et_b, m_et);
    chk("escape_trig_small", et_s, m_et);
  endtask

  task automatic step(input logic r, input logic ld, input logic [N-1:0] lv,
                      input logic [LW-1:0] lf, input logic [N-1:0] h, input logic clr);
    rst_n = r; load = ld; loadval = lv; life = lf; hit = h; clear_score = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; loadval = '0; life = '0; hit = '0; clear_score = 1'b0;

    step(1'b0, 1'b1, 5'b11111, 8'd3, 5'b11111, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("reset_board", board_b, 5'b00000);
    chk("reset_score", score_b, 0);
    chk("reset_triggers", {st_b, mt_b, et_b}, 3'b000);

    step(1'b1, 1'b1, 5'b10101, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b00101, 1'b0);
    chk("hit2_board", board_b, 5'b10000);
    chk("hit2_score", score_b, 2);
    chk("hit2_trig", st_b, 1'b1);
    idle();
    chk("hit2_trig_drop", st_b, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b10000, 1'b0);
    chk("hit3_score", score_b, 3);

    step(1'b1, 1'b1, 5'b00010, 8'd3, '0, 1'b0);
    chk("life3_c0", board_b, 5'b00010);
    idle();
    chk("life3_c1", board_b, 5'b00010);
    idle();
    chk("life3_c2", board_b, 5'b00010);
    idle();
    chk("life3_gone", board_b, 5'b00000);
    chk("life3_escape", et_b, 1'b1);
    chk("life3_score", score_b, 3);
    idle();
    chk("life3_escape_drop", et_b, 1'b0);

    step(1'b1, 1'b1, 5'b00001, 8'd0, '0, 1'b0);
    step(1'b1, 1'b1, 5'b00001, 8'd7, 5'b00001, 1'b0);
    chk("reload_score", score_b, 4);
    chk("reload_board", board_b, 5'b00001);
    for (int k = 0; k < 6; k++) begin
      idle();
      chk("reload_alive", board_b, 5'b00001);
    end
    idle();
    chk("reload_escape", et_b, 1'b1);

    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 5'b00001, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b00001, 1'b0);
    chk("pre_miss_score", score_b, 1);
    step(1'b1, 1'b0, '0, '0, 5'b00110, 1'b0);
`ifdef MOLE_MISS_PENALTY_EN
    chk("miss_score", score_b, 0);
    chk("miss_trig", mt_b, 1'b1);
`else
    chk("miss_score", score_b, 1);
    chk("miss_trig", mt_b, 1'b0);
`endif

    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 5'b11111, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b11111, 1'b0);
    step(1'b1, 1'b1, 5'b11111, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b11111, 1'b0);
    step(1'b1, 1'b1, 5'b01111, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b01111, 1'b0);
    chk("sat_pre", score_s, 14);
    step(1'b1, 1'b1, 5'b00011, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b00011, 1'b0);
    chk("sat_small", score_s, 15);
    chk("sat_big", score_b, 16);
    step(1'b1, 1'b1, 5'b00001, 8'd0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'b00001, 1'b1);
    chk("clear_score_small", score_s, 0);
    chk("clear_score_big", score_b, 0);
    chk("clear_trig", st_s, 1'b1);

    step(1'b1, 1'b1, 5'b11111, 8'd200, '0, 1'b0);
    chk("full_board", board_b, 5'b11111);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("midreset_board", board_b, 5'b00000);
    chk("midreset_score", score_b, 0);
    for (int k = 0; k < 220; k++) begin
      idle();
      chk("no_escape_after_reset", et_b, 1'b0);
    end

    for (int c = 0; c < 2000; c++) begin
      logic          r, ld, clr;
      logic [N-1:0]  lv, h;
      logic [LW-1:0] lf;
      r   = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      lv  = N'($urandom);
      lf  = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
      h   = N'($urandom) & N'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      step(r, ld, lv, lf, h, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_board.md
MOLE_BOARD -- requirements
Module: mole_board

Interface
REQ-001 Parameters SHALL be: N_HOLES, default 5, number of holes; LIFE_W, default 8, lifetime counter width; SCORE_W, default 8, score width.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  active-high; load loadval into board this cycle.
REQ-005 loadval  input  N_HOLES  active-high; holes to activate.
REQ-006 life  input  LIFE_W  lifetime in cycles for holes loaded this cycle; 0 = never expire.
REQ-007 hit  input  N_HOLES  active-high single-cycle pulses, already debounced and edge-detected upstream.
REQ-008 clear_score  input  1  active-high; zero score.
REQ-009 score_trigger  output  1  one-cycle pulse; at least one active mole hit.
REQ-010 miss_trigger  output  1  one-cycle pulse; at least one hit on an inactive hole.
REQ-011 escape_trigger  output  1  one-cycle pulse; at least one mole expired.
REQ-012 board_state  output  N_HOLES  active-high; currently active moles.
REQ-013 score  output  SCORE_W  unsigned running score.

Function
REQ-014 All outputs SHALL be registered; the response to inputs sampled at edge k SHALL be visible after edge k.
REQ-015 Each hole SHALL hold an active bit and a LIFE_W down-counter.
REQ-016 Valid hit on hole i (hit[i] and active[i]) SHALL clear active[i] and count toward score.
REQ-017 Score SHALL increase by the popcount of valid hits in the cycle, saturating at 2^SCORE_W-1.
REQ-018 Simultaneous valid hits on several holes SHALL all count in the same cycle, with a single score_trigger pulse.
REQ-019 An active hole with a nonzero counter SHALL decrement once per cycle.
REQ-020 A hole whose counter is 1 and which is not validly hit that cycle SHALL clear and raise escape_trigger; a hit on the final cycle counts as a hit, not an escape.
REQ-021 A hole loaded with life=0 SHALL stay active until hit or reloaded.
REQ-022 On load, hits and expiry SHALL be evaluated against the pre-load state first.
REQ-023 On load, for each i with loadval[i]=1, active[i] SHALL become 1 and its counter SHALL become life, overriding a same-cycle hit clear or expiry.
REQ-024 On load, holes with loadval[i]=0 SHALL keep their post-hit/expiry state (OR-merge, not overwrite).
REQ-025 clear_score SHALL set score to 0 and take priority over same-cycle increments and decrements; triggers SHALL still pulse.
REQ-026 Trigger outputs SHALL be 0 in any cycle with no corresponding event.

Reset
REQ-027 While rst_n=0 at a clock edge, board_state, all counters, score and all triggers SHALL become 0; load and hit SHALL be ignored that cycle.
REQ-028 Reset asserted mid-game SHALL discard pending lifetimes; the first post-reset cycle SHALL behave as an empty board.

Configuration
REQ-029 Macro MOLE_MISS_PENALTY_EN defined: each hit on an inactive hole SHALL decrement score by 1 (popcount of misses, saturating at 0, applied after hit increments) and pulse miss_trigger.
REQ-030 Macro MOLE_MISS_PENALTY_EN undefined: misses SHALL not affect score, and miss_trigger SHALL be constant 0.

Structure
REQ-031 Package mole_pkg SHALL hold default N_HOLES, LIFE_W and SCORE_W constants and a saturating-add/sub width rule constant.
REQ-032 Sub-module mole_slot SHALL implement one hole (active bit, counter, hit/expire/load outputs); mole_board SHALL instantiate N_HOLES slots via generate and perform popcount and scoring.

Verification
REQ-033 Reset, then load=1, loadval=5'b10101, life=0, then hit=5'b00101 -> next cycle board_state=5'b10000, score=2, score_trigger=1 for one cycle.
REQ-034 Load 5'b00010 with life=3, no hits -> board_state[1] high for 3 cycles, then clears with escape_trigger=1 for one cycle; score unchanged.
REQ-035 Same cycle: board 5'b00001 active, hit=5'b00001, load=1, loadval=5'b00001 -> score+1 and board_state[0] remains 1 with counter=life.
REQ-036 MOLE_MISS_PENALTY_EN defined, score=1, hit=5'b00110 on empty board -> score=0 (saturates), miss_trigger=1; undefined -> score=1, miss_trigger=0.
REQ-037 SCORE_W=4, score=14, two valid hits -> score=15 (saturated); then clear_score together with a valid hit -> score=0, score_trigger=1.
REQ-038 rst_n=0 for one cycle with board 5'b11111 and life=200 -> board_state=0, score=0; no escape_trigger afterwards.
